capture_sequencer: RTL
======================

Name: capture_sequencer

Overview:
Sequences one logic-analyzer acquisition and its readback. It owns the sample RAM port: it writes divided samples into a ring buffer while armed and through the post-trigger delay. It then reads the buffer newest-to-oldest and streams the samples as bytes to the UART transmitter. It sits between the command controller (arm/abort), the trigger (run), the clock divider (sample strobe), the sample RAM and the data side of the data/meta mux.

Parameters:
SAMPLE_WIDTH, 8, width of one sample; must be a multiple of 8, from 8 to 32
ADDR_WIDTH, 10, sample RAM address width; depth = 2^ADDR_WIDTH

Ports:
clock  input  1  system clock
reset_n  input  1  synchronous, active-low reset
arm  input  1  one-cycle pulse from controller; starts acquisition
abort  input  1  one-cycle pulse (reset opcode); returns to IDLE
run  input  1  trigger fired (level or pulse)
sample_valid  input  1  divider strobe; sample_in valid this cycle
sample_in  input  SAMPLE_WIDTH  sample from input stage
read_count  input  16  total samples to return
delay_count  input  16  samples captured after trigger
mem_we  output  1  RAM write enable
mem_addr  output  ADDR_WIDTH  RAM address (shared read/write)
mem_wdata  output  SAMPLE_WIDTH  RAM write data
mem_rdata  input  SAMPLE_WIDTH  RAM read data, 1-cycle latency after mem_addr
tx_data  output  8  byte to UART transmitter
tx_start  output  1  one-cycle send request
transmit_busy  input  1  UART transmitter busy
busy  output  1  high in any state other than IDLE
capture_done  output  1  one-cycle pulse when last byte accepted

Behaviour:
- Reset (reset_n low at a clock edge): state IDLE, write pointer 0, all counters 0, every output 0.
- abort has priority over all other inputs in every state. IDLE on the next edge, mem_we and tx_start forced 0 the same cycle, no capture_done. The write pointer is kept.
- States: IDLE, ARMED, DELAY, READ_ADDR, READ_DATA, TX_BYTE, TX_WAIT, DONE.
- IDLE: on arm, latch read_count and delay_count. Effective read count = min(read_count, 2^ADDR_WIDTH). Go to ARMED. run ignored.
- ARMED: each sample_valid cycle drives mem_we=1, mem_addr=wptr, mem_wdata=sample_in (combinational in that cycle). wptr increments, wrapping mod 2^ADDR_WIDTH.
  - On run: go to DELAY, with delay counter = latched delay_count.
  - If run and sample_valid coincide, that sample is written and does not count toward delay.
  - If delay_count=0, go straight to READ_ADDR.
- DELAY: same writes as ARMED. Each write decrements the delay counter. The write that makes it 0 is the last; READ_ADDR follows on the next cycle. run and arm ignored.
- Readout order: first sample read is at address wptr-1 (newest), then decrementing with wrap. Total = effective read count.
  - If effective read count = 0, go READ_ADDR -> DONE; no bytes are sent.
- READ_ADDR: drive mem_addr, mem_we=0. READ_DATA: register mem_rdata into a shift register; byte index = 0.
- TX_BYTE: entered only with transmit_busy=0. tx_data = byte[index], least-significant byte first, and tx_start=1 for exactly one cycle. Next state TX_WAIT.
- TX_WAIT: ignore transmit_busy in its first cycle. Leave when transmit_busy is observed 0:
  - If more bytes remain in the sample (SAMPLE_WIDTH/8 per sample): TX_BYTE.
  - Else if more samples remain: READ_ADDR.
  - Else: DONE.
- If transmit_busy is still high when TX_BYTE would be entered, hold in TX_WAIT. tx_start is never asserted while transmit_busy=1.
- DONE: capture_done=1 for one cycle, then IDLE.
- tx_data holds its last value between tx_start pulses. mem_wdata/mem_addr are don't-care when mem_we=0, except mem_addr during READ_ADDR.
- arm in any state other than IDLE is ignored.
- The buffer is not cleared between captures. If fewer samples were written than requested, stale or reset-value data is returned. This is required behaviour, not an error.

Test Plan:
- Basic: ADDR_WIDTH=4, arm, 6 samples 0x01..0x06, run with sample 0x07, delay_count=2 (0x08, 0x09), read_count=4 -> TX bytes 0x09,0x08,0x07,0x06, then one capture_done pulse.
- Wrap: ADDR_WIDTH=4, write 20 samples 0x00..0x13 pre-trigger, delay 0, read_count=16 -> bytes 0x13 down to 0x04, with addresses wrapping 3 -> 2 -> 1 -> 0 -> 15.
- Wide/backpressure: SAMPLE_WIDTH=16, read 1 sample 0xA55A, hold transmit_busy high 10 cycles after each start -> bytes 0x5A then 0xA5. No tx_start while busy. Exactly 2 starts.
- Limits: read_count=0 -> no tx_start, capture_done 2-3 cycles after the delay completes. read_count=0xFFFF with ADDR_WIDTH=4 -> exactly 16 bytes.
- Abort/reset mid-TX: abort during 3rd byte's TX_WAIT -> IDLE next cycle, busy=0, no further tx_start, no capture_done. reset_n low in DELAY -> all outputs 0 on the next edge, wptr=0.
- Ignored inputs: run in IDLE, arm during DELAY, run with sample_valid coincident in ARMED -> no state change / no restart / coincident sample written but not counted toward delay.

Source files
------------

// File: rtl/capture_sequencer.sv
// Capture sequencer: fills the sample ring buffer around a trigger, then streams
// the newest samples to the UART transmitter, least-significant byte first.
module capture_sequencer #(
    parameter int unsigned SAMPLE_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH   = 10
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    arm,
    input  logic                    abort,
    input  logic                    run,
    input  logic                    sample_valid,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic [15:0]             read_count,
    input  logic [15:0]             delay_count,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [SAMPLE_WIDTH-1:0] mem_wdata,
    input  logic [SAMPLE_WIDTH-1:0] mem_rdata,
    output logic [7:0]              tx_data,
    output logic                    tx_start,
    input  logic                    transmit_busy,
    output logic                    busy,
    output logic                    capture_done
);

    localparam int unsigned NBYTES = SAMPLE_WIDTH / 8;
    localparam int unsigned BI_W   = $clog2(NBYTES + 1);
    localparam int unsigned CNT_W  = (ADDR_WIDTH + 1 > 16) ? ADDR_WIDTH + 1 : 16;
    localparam logic [31:0] DEPTH  = 32'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_DELAY,
        S_READ_ADDR,
        S_READ_DATA,
        S_TX_BYTE,
        S_TX_WAIT,
        S_DONE
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   wptr;
    logic [ADDR_WIDTH-1:0]   rd_idx;
    logic [15:0]             delay_lat;
    logic [15:0]             delay_left;
    logic [CNT_W-1:0]        eff_count;
    logic [CNT_W-1:0]        samples_left;
    logic [SAMPLE_WIDTH-1:0] shreg;
    logic [BI_W-1:0]         byte_idx;
    logic                    wait_first;

    logic                    write_c;
    logic [CNT_W-1:0]        eff_count_c;

    // Sample writes are combinational so the strobe cycle itself lands in RAM.
    assign write_c      = (state == S_ARMED || state == S_DELAY) && sample_valid && !abort;
    assign mem_we       = write_c;
    assign mem_wdata    = write_c ? sample_in : '0;
    assign mem_addr     = write_c ? wptr :
                          (state == S_READ_ADDR) ? wptr - ADDR_WIDTH'(1) - rd_idx : '0;
    assign tx_start     = (state == S_TX_BYTE) && !abort;
    assign busy         = (state != S_IDLE);
    assign capture_done = (state == S_DONE);

    // Never return more samples than the ring can hold.
    assign eff_count_c  = (32'(read_count) > DEPTH) ? CNT_W'(DEPTH) : CNT_W'(read_count);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            wptr         <= '0;
            rd_idx       <= '0;
            delay_lat    <= '0;
            delay_left   <= '0;
            eff_count    <= '0;
            samples_left <= '0;
            shreg        <= '0;
            byte_idx     <= '0;
            wait_first   <= 1'b0;
            tx_data      <= '0;
        end else if (abort) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arm) begin
                        eff_count <= eff_count_c;
                        delay_lat <= delay_count;
                        state     <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (sample_valid) begin
                        wptr <= wptr + ADDR_WIDTH'(1);
                    end
                    if (run) begin
                        delay_left <= delay_lat;
                        if (delay_lat == 16'd0) begin
                            rd_idx       <= '0;
                            samples_left <= eff_count;
                            state        <= S_READ_ADDR;
                        end else begin
                            state <= S_DELAY;
                        end
                    end
                end
                S_DELAY: begin
                    if (sample_valid) begin
                        wptr       <= wptr + ADDR_WIDTH'(1);
                        delay_left <= delay_left - 16'd1;
                        if (delay_left == 16'd1) begin
                            rd_idx       <= '0;
                            samples_left <= eff_count;
                            state        <= S_READ_ADDR;
                        end
                    end
                end
                S_READ_ADDR: begin
                    state <= (samples_left == '0) ? S_DONE : S_READ_DATA;
                end
                S_READ_DATA: begin
                    shreg        <= mem_rdata;
                    byte_idx     <= '0;
                    samples_left <= samples_left - CNT_W'(1);
                    rd_idx       <= rd_idx + ADDR_WIDTH'(1);
                    if (!transmit_busy) begin
                        tx_data <= mem_rdata[7:0];
                        state   <= S_TX_BYTE;
                    end else begin
                        wait_first <= 1'b0;
                        state      <= S_TX_WAIT;
                    end
                end
                S_TX_BYTE: begin
                    shreg      <= shreg >> 8;
                    byte_idx   <= byte_idx + BI_W'(1);
                    wait_first <= 1'b1;
                    state      <= S_TX_WAIT;
                end
                S_TX_WAIT: begin
                    // Busy may lag the start pulse by a cycle, so the first cycle is blind.
                    wait_first <= 1'b0;
                    if (!wait_first && !transmit_busy) begin
                        if (byte_idx != BI_W'(NBYTES)) begin
                            tx_data <= shreg[7:0];
                            state   <= S_TX_BYTE;
                        end else if (samples_left != '0) begin
                            state <= S_READ_ADDR;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
